// File: rtl/rr_outport_sched.sv
// Output-port switch scheduler: round-robin arbitration among NR inputs with
// wormhole packet locking and credit-based flow control toward the downstream buffer.
module rr_outport_sched #(
  parameter int unsigned NR       = 5,
  parameter int unsigned CRED_MAX = 4,
  parameter int unsigned CW       = $clog2(CRED_MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NR-1:0] req_i,
  input  logic [NR-1:0] tail_i,
  input  logic          credit_in_i,
  output logic [NR-1:0] grt_o,
  output logic          flit_vld_o,
  output logic          busy_o,
  output logic [CW-1:0] credit_cnt_o,
  output logic          cred_err_o
);

  localparam int unsigned OW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e        state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] ptr_q;
  logic          busy_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [OW-1:0] win;
  logic          xfer;
  logic          tail_w;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] w);
    return (w == OW'(NR - 1)) ? '0 : w + OW'(1);
  endfunction

  // Grant is combinational from the registered count, so a same-cycle credit
  // pulse never enables a grant; reset masks the grant immediately.
  always_comb begin
    int unsigned idx;
    win  = '0;
    xfer = 1'b0;
    idx  = 0;
    if (!rst_i && cnt_q != '0) begin
      if (state_q == LOCKED) begin
        win  = owner_q;
        xfer = req_i[owner_q];
      end else begin
        for (int unsigned k = 0; k < NR; k++) begin
          idx = int'(ptr_q) + k;
          if (idx >= NR) idx = idx - NR;
          if (!xfer && req_i[OW'(idx)]) begin
            xfer = 1'b1;
            win  = OW'(idx);
          end
        end
      end
    end
  end

  assign tail_w     = tail_i[win];
  assign grt_o      = xfer ? (NR'(1) << win) : '0;
  assign flit_vld_o = xfer;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (xfer && !credit_in_i) begin
      cnt_d = cnt_q - CW'(1);
    end else if (credit_in_i && !xfer) begin
      if (cnt_q == CW'(CRED_MAX)) err_d = 1'b1;
      else                        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= CW'(CRED_MAX);
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (tail_w) begin
              ptr_q <= next_idx(win);
            end else begin
              state_q <= LOCKED;
              owner_q <= win;
              busy_q  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (xfer && tail_w) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= next_idx(owner_q);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign credit_cnt_o = cnt_q;
  assign cred_err_o   = err_q;

endmodule

// File: tb/tb_rr_outport_sched.sv
// Directed bench for rr_outport_sched: arbitration, packet locking, credits and reset.
module tb_rr_outport_sched;

  localparam int NR = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] tail;
  logic          credit_in;
  logic [NR-1:0] grt;
  logic          flit_vld;
  logic          busy;
  logic [CW-1:0] cnt;
  logic          err;

  int passed = 0;
  int total  = 0;

  rr_outport_sched #(.NR(NR), .CRED_MAX(4), .CW(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .tail_i       (tail),
    .credit_in_i  (credit_in),
    .grt_o        (grt),
    .flit_vld_o   (flit_vld),
    .busy_o       (busy),
    .credit_cnt_o (cnt),
    .cred_err_o   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 5'b11111; tail = '0; credit_in = 1'b0;
    @(negedge clk);
    total++; if (grt !== 5'b00000) $display("FAIL reset_grt got %b exp 00000", grt); else passed++;
    total++; if (flit_vld !== 1'b0) $display("FAIL reset_vld got %b exp 0", flit_vld); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (cnt !== 3'd4) $display("FAIL reset_cnt got %0d exp 4", cnt); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
    rst = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_rr_wrap();
    logic [NR-1:0] eg [4];
    eg[0] = 5'b00001; eg[1] = 5'b10000; eg[2] = 5'b00001; eg[3] = 5'b10000;
    credit_in = 1'b1; tail = 5'b11111; req = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (grt !== eg[i]) $display("FAIL rr_grt%0d got %b exp %b", i, grt, eg[i]); else passed++;
      total++; if (flit_vld !== 1'b1) $display("FAIL rr_vld%0d got %b exp 1", i, flit_vld); else passed++;
      total++; if (cnt !== 3'd4) $display("FAIL rr_cnt%0d got %0d exp 4", i, cnt); else passed++;
      tick();
    end
    req = '0; credit_in = 1'b0;
    @(negedge clk);
    total++; if (cnt !== 3'd4) $display("FAIL rr_cnt_end got %0d exp 4", cnt); else passed++;
    tick();
  endtask

  task automatic test_wormhole();
    credit_in = 1'b1; req = 5'b00011;
    for (int i = 0; i < 4; i++) begin
      tail = (i == 3) ? 5'b00001 : 5'b00000;
      @(negedge clk);
      total++; if (grt !== 5'b00001) $display("FAIL worm_grt%0d got %b exp 00001", i, grt); else passed++;
      total++; if (busy !== (i != 0)) $display("FAIL worm_busy%0d got %b exp %b", i, busy, (i != 0)); else passed++;
      tick();
    end
    tail = 5'b00011;
    @(negedge clk);
    total++; if (grt !== 5'b00010) $display("FAIL worm_next_grt got %b exp 00010", grt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL worm_next_busy got %b exp 0", busy); else passed++;
    tick();
    req = '0; credit_in = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL worm_single_busy got %b exp 0", busy); else passed++;
    total++; if (cnt !== 3'd4) $display("FAIL worm_cnt got %0d exp 4", cnt); else passed++;
    tick();
  endtask

  task automatic test_credit_starve();
    credit_in = 1'b0; req = 5'b00100; tail = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (grt !== 5'b00100) $display("FAIL starve_grt%0d got %b exp 00100", i, grt); else passed++;
      total++; if (cnt !== CW'(4 - i)) $display("FAIL starve_cnt%0d got %0d exp %0d", i, cnt, 4 - i); else passed++;
      tick();
    end
    @(negedge clk);
    total++; if (grt !== 5'b00000) $display("FAIL starve_empty_grt got %b exp 00000", grt); else passed++;
    total++; if (flit_vld !== 1'b0) $display("FAIL starve_empty_vld got %b exp 0", flit_vld); else passed++;
    total++; if (cnt !== 3'd0) $display("FAIL starve_empty_cnt got %0d exp 0", cnt); else passed++;
    tick();
    credit_in = 1'b1;
    @(negedge clk);
    total++; if (grt !== 5'b00000) $display("FAIL starve_pulse_grt got %b exp 00000", grt); else passed++;
    tick();
    credit_in = 1'b0;
    @(negedge clk);
    total++; if (cnt !== 3'd1) $display("FAIL starve_refill_cnt got %0d exp 1", cnt); else passed++;
    total++; if (grt !== 5'b00100) $display("FAIL starve_refill_grt got %b exp 00100", grt); else passed++;
    tick();
    @(negedge clk);
    total++; if (cnt !== 3'd0) $display("FAIL starve_again_cnt got %0d exp 0", cnt); else passed++;
    total++; if (grt !== 5'b00000) $display("FAIL starve_again_grt got %b exp 00000", grt); else passed++;
    req = '0;
    tick();
  endtask

  task automatic test_simul_overflow();
    req = '0; credit_in = 1'b1;
    tick();
    tick();
    req = 5'b00100; tail = 5'b11111;
    @(negedge clk);
    total++; if (cnt !== 3'd2) $display("FAIL simul_pre_cnt got %0d exp 2", cnt); else passed++;
    total++; if (grt !== 5'b00100) $display("FAIL simul_grt got %b exp 00100", grt); else passed++;
    tick();
    req = '0;
    @(negedge clk);
    total++; if (cnt !== 3'd2) $display("FAIL simul_post_cnt got %0d exp 2", cnt); else passed++;
    tick();
    tick();
    @(negedge clk);
    total++; if (cnt !== 3'd4) $display("FAIL ovf_full_cnt got %0d exp 4", cnt); else passed++;
    total++; if (err !== 1'b0) $display("FAIL ovf_pre_err got %b exp 0", err); else passed++;
    tick();
    credit_in = 1'b0;
    @(negedge clk);
    total++; if (cnt !== 3'd4) $display("FAIL ovf_cnt got %0d exp 4", cnt); else passed++;
    total++; if (err !== 1'b1) $display("FAIL ovf_err got %b exp 1", err); else passed++;
    tick();
    tick();
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL ovf_err_sticky got %b exp 1", err); else passed++;
    tick();
  endtask

  task automatic test_owner_stall();
    credit_in = 1'b0; req = 5'b00010; tail = 5'b00000;
    @(negedge clk);
    total++; if (grt !== 5'b00010) $display("FAIL stall_lock_grt got %b exp 00010", grt); else passed++;
    tick();
    req = 5'b00100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (grt !== 5'b00000) $display("FAIL stall_grt%0d got %b exp 00000", i, grt); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL stall_busy%0d got %b exp 1", i, busy); else passed++;
      total++; if (cnt !== 3'd3) $display("FAIL stall_cnt%0d got %0d exp 3", i, cnt); else passed++;
      tick();
    end
    req = 5'b00110; tail = 5'b00010;
    @(negedge clk);
    total++; if (grt !== 5'b00010) $display("FAIL stall_resume_grt got %b exp 00010", grt); else passed++;
    tick();
    req = 5'b00111; tail = 5'b11111;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL stall_release_busy got %b exp 0", busy); else passed++;
    total++; if (cnt !== 3'd2) $display("FAIL stall_release_cnt got %0d exp 2", cnt); else passed++;
    total++; if (grt !== 5'b00100) $display("FAIL stall_ptr_grt got %b exp 00100", grt); else passed++;
    tick();
    req = '0;
  endtask

  task automatic test_reset_mid_packet();
    req = 5'b01000; tail = 5'b00000; credit_in = 1'b1;
    @(negedge clk);
    total++; if (grt !== 5'b01000) $display("FAIL rstmid_lock_grt got %b exp 01000", grt); else passed++;
    tick();
    req = '0; credit_in = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rstmid_pre_busy got %b exp 1", busy); else passed++;
    total++; if (cnt !== 3'd1) $display("FAIL rstmid_pre_cnt got %0d exp 1", cnt); else passed++;
    #1;
    req = 5'b01000;
    rst = 1'b1;
    #1;
    total++; if (grt !== 5'b00000) $display("FAIL rstmid_grt got %b exp 00000", grt); else passed++;
    total++; if (flit_vld !== 1'b0) $display("FAIL rstmid_vld got %b exp 0", flit_vld); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else passed++;
    total++; if (cnt !== 3'd4) $display("FAIL rstmid_cnt got %0d exp 4", cnt); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rstmid_err got %b exp 0", err); else passed++;
    tick();
    rst = 1'b0; req = 5'b01001; tail = 5'b00000;
    @(negedge clk);
    total++; if (grt !== 5'b00001) $display("FAIL rstmid_after_grt got %b exp 00001", grt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_after_busy got %b exp 0", busy); else passed++;
    tick();
    req = '0;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rstmid_relock_busy got %b exp 1", busy); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_rr_wrap();
    test_wormhole();
    test_credit_starve();
    test_simul_overflow();
    test_owner_stall();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_outport_sched.md
# rr_outport_sched

Per-output-port switch scheduler for the router. Shares one output port (and its downstream buffer) among NR input ports. Combines round-robin selection with wormhole packet locking and credit-based flow control. One instance sits in front of each crossbar output and drives that column's crossbar select.

## Interface
- NR, 5: number of requesting input ports.
- CRED_MAX, 4: downstream buffer depth in flits; also the reset value of the credit count.
- CW, $clog2(CRED_MAX+1): width of the credit counter.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  NR  bit i: input i presents a flit destined for this output.
- TAIL  in  NR  bit i: the flit presented by input i is a packet tail. Single-flit packets set TAIL on the head.
- CREDIT_IN  in  1  one-cycle pulse: downstream freed one buffer slot.
- GRT  out  NR  one-hot or zero; the granted input transfers its flit this cycle.
- FLIT_VLD  out  1  equals |GRT; a flit crosses the output this cycle.
- BUSY  out  1  high while a packet lock is held (state LOCKED).
- CREDIT_CNT  out  CW  current credit count.
- CRED_ERR  out  1  sticky; set on credit overflow.

## Operation
- State machine, two states:
  - IDLE: no packet owns the port.
  - LOCKED: register OWNER holds the input index that owns the port.
- Registered state: STATE, OWNER, PTR (round-robin priority pointer, 0..NR-1), CREDIT_CNT, CRED_ERR.
- Credits available: CREDIT_CNT != 0, using the registered value.
- Grant in IDLE:
  - If credits are available and REQ != 0, grant the first set REQ bit searching PTR, PTR+1, … with wrap modulo NR.
  - Otherwise GRT = 0.
- Grant in LOCKED:
  - GRT = one-hot(OWNER) if REQ[OWNER] and credits are available; otherwise 0.
  - Other requesters are never granted while LOCKED, even if the owner is idle.
- Transfer (FLIT_VLD = 1), winner w:
  - IDLE, TAIL[w] = 0: go to LOCKED, OWNER <= w. PTR unchanged.
  - IDLE, TAIL[w] = 1 (single-flit packet): stay IDLE, PTR <= (w+1) mod NR.
  - LOCKED, TAIL[OWNER] = 1: go to IDLE, PTR <= (OWNER+1) mod NR.
  - LOCKED, TAIL[OWNER] = 0: stay LOCKED.
- Credit counter update:
  - Transfer only: decrement.
  - CREDIT_IN only: increment.
  - Transfer and CREDIT_IN together: unchanged.
  - CREDIT_IN with CREDIT_CNT = CRED_MAX and no transfer: count stays at CRED_MAX, CRED_ERR <= 1.
  - The count never underflows, because a grant requires a nonzero count.
- CRED_ERR clears only on reset.
- PTR wrap: NR-1 advances to 0.
- Reset asserted at any time, including mid-packet: the lock is dropped, with no tail required.

## Timing
- Reset values: STATE = IDLE, OWNER = 0, PTR = 0, CREDIT_CNT = CRED_MAX, CRED_ERR = 0, BUSY = 0.
- GRT and FLIT_VLD are forced to 0 while RST is high, regardless of REQ.
- GRT and FLIT_VLD are combinational from current REQ/TAIL and registered state: zero-cycle grant latency. The flit transfers in the same cycle REQ is seen.
- BUSY, PTR, OWNER, CREDIT_CNT and CRED_ERR take their new values on the edge after the transfer or credit event.
- A CREDIT_IN pulse cannot enable a grant in the same cycle. When CREDIT_CNT = 0, the earliest grant is the cycle after CREDIT_IN.
- Back-to-back packets: a tail in cycle n lets a different input be granted in cycle n+1. There is no bubble.
- REQ and TAIL may change every cycle. TAIL is ignored for non-granted inputs.

## Test plan
- Round-robin wrap (NR=5, CREDIT_IN=1 every cycle, TAIL=5'b11111, REQ=5'b10001 held): GRT 00001, 10000, 00001, 10000; PTR 1, 0, 1, 0; CREDIT_CNT stays 4.
- Wormhole lock: REQ=5'b00011; input 0 sends 4 flits with TAIL[0] set only on the 4th. Required: GRT=00001 for 4 cycles, BUSY=1 from the 2nd through the 4th cycle, then GRT=00010 with BUSY=0.
- Credit starvation (CREDIT_IN=0, REQ=5'b00100, TAIL=1): 4 grants take CREDIT_CNT 4→0, then GRT=0. One CREDIT_IN pulse gives CREDIT_CNT=1 on the next cycle, one grant, then 0 again.
- Simultaneous events and overflow:
  - Transfer plus CREDIT_IN at count 2: count stays 2.
  - CREDIT_IN at count 4 with REQ=0: count stays 4, CRED_ERR=1 and stays set until RST.
- Owner stall: input 1 is LOCKED and REQ=5'b00100 (owner deasserted). Required: GRT=0, BUSY=1, no credit change. Restoring REQ[1] with TAIL gives GRT=00010, then PTR=2.
- Reset mid-packet: assert RST while LOCKED with OWNER=3 and CREDIT_CNT=1. Required: immediately GRT=0, BUSY=0, CREDIT_CNT=4, PTR=0. After release with REQ=5'b01001, GRT=00001.
